hasti_slave_demux: RTL and testbench

Single-slave-to-many AHB-Lite (Hasti) address decoder and response multiplexer: accepts one slave-side port, such as the output of the arbitrating slave mux, and fans it out to three memory-mapped slave ports. It decodes each address phase to a one-hot slave select and registers the data-phase owner. It returns that slave's hrdata, hreadyout and hresp upstream. Unmapped transfers go to an internal default slave.

---
 rtl/hasti_slave_demux_if.sv | 51 +++++
 rtl/hasti_slave_demux.sv | 134 +++++++++++++
 tb/tb_hasti_slave_demux.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hasti_slave_demux_if.sv
// Bus bundle between one upstream Hasti port and three downstream slaves.
// in_* is the upstream slave-side port; outs_* is the fan-out to the slaves.
interface hasti_slave_demux_if;
    logic [31:0] in_haddr;
    logic        in_hwrite;
    logic [2:0]  in_hsize;
    logic [2:0]  in_hburst;
    logic [3:0]  in_hprot;
    logic [1:0]  in_htrans;
    logic        in_hmastlock;
    logic [31:0] in_hwdata;
    logic        in_hsel;
    logic        in_hreadyin;
    logic [31:0] in_hrdata;
    logic        in_hreadyout;
    logic        in_hresp;

    logic [31:0] outs_haddr;
    logic        outs_hwrite;
    logic [2:0]  outs_hsize;
    logic [2:0]  outs_hburst;
    logic [3:0]  outs_hprot;
    logic [1:0]  outs_htrans;
    logic        outs_hmastlock;
    logic [31:0] outs_hwdata;
    logic        outs_hreadyin;
    logic [2:0]  outs_hsel;
    logic [95:0] outs_hrdata;
    logic [2:0]  outs_hreadyout;
    logic [2:0]  outs_hresp;

    // View taken by the demux itself.
    modport slave (
        input  in_haddr, in_hwrite, in_hsize, in_hburst, in_hprot, in_htrans,
               in_hmastlock, in_hwdata, in_hsel, in_hreadyin,
               outs_hrdata, outs_hreadyout, outs_hresp,
        output in_hrdata, in_hreadyout, in_hresp,
               outs_haddr, outs_hwrite, outs_hsize, outs_hburst, outs_hprot,
               outs_htrans, outs_hmastlock, outs_hwdata, outs_hreadyin, outs_hsel
    );

    // View taken by the surrounding system (upstream master plus slaves).
    modport master (
        output in_haddr, in_hwrite, in_hsize, in_hburst, in_hprot, in_htrans,
               in_hmastlock, in_hwdata, in_hsel, in_hreadyin,
               outs_hrdata, outs_hreadyout, outs_hresp,
        input  in_hrdata, in_hreadyout, in_hresp,
               outs_haddr, outs_hwrite, outs_hsize, outs_hburst, outs_hprot,
               outs_htrans, outs_hmastlock, outs_hwdata, outs_hreadyin, outs_hsel
    );
endinterface

// File: rtl/hasti_slave_demux.sv
// AHB-Lite address decoder / response mux fanning one port out to three slaves.
// Define HASTI_DEMUX_ERRSLV_EN to make unmapped accesses return a 2-cycle ERROR.
module hasti_slave_demux #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_BASE = 32'h1000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
    input  logic                clk,
    input  logic                reset,
    hasti_slave_demux_if.slave  io
);
    localparam logic [2:0][31:0] L_BASE = {S2_BASE, S1_BASE, S0_BASE};
    localparam logic [2:0][31:0] L_MASK = {S2_MASK, S1_MASK, S0_MASK};
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    logic [2:0]  w_match;
    logic [2:0]  w_first;
    logic        w_active;
    logic        w_unmapped;
    logic [3:0]  w_dsel_next;
    logic [3:0]  r_dsel;
    logic [31:0] w_hrdata;
    logic        w_hreadyout;
    logic        w_hresp;
    logic        w_def_hreadyout;
    logic        w_def_hresp;

    assign io.outs_haddr     = io.in_haddr;
    assign io.outs_hwrite    = io.in_hwrite;
    assign io.outs_hsize     = io.in_hsize;
    assign io.outs_hburst    = io.in_hburst;
    assign io.outs_hprot     = io.in_hprot;
    assign io.outs_htrans    = io.in_htrans;
    assign io.outs_hmastlock = io.in_hmastlock;
    assign io.outs_hwdata    = io.in_hwdata;
    assign io.outs_hreadyin  = io.in_hreadyin;

    // Lowest index wins when regions overlap.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            localparam logic [2:0] LOWER = 3'((1 << gi) - 1);
            assign w_match[gi]     = (io.in_haddr & L_MASK[gi]) == L_BASE[gi];
            assign w_first[gi]     = w_match[gi] & ~|(w_match & LOWER);
            assign io.outs_hsel[gi] = io.in_hsel & w_first[gi];
        end
    endgenerate

    assign w_active    = io.in_hsel &&
                         (io.in_htrans == HTRANS_NONSEQ || io.in_htrans == HTRANS_SEQ);
    assign w_unmapped  = w_active & ~|w_match;
    assign w_dsel_next = w_active ? {w_unmapped, w_first} : 4'b0000;

    // Data-phase owner: {DEF, S2, S1, S0}, all-zero means no data phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dsel <= 4'b0000;
        end else if (io.in_hreadyin) begin
            r_dsel <= w_dsel_next;
        end
    end

`ifdef HASTI_DEMUX_ERRSLV_EN
    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    ds_state_t r_ds_state;
    ds_state_t w_ds_state_next;
    logic      w_accept_unmapped;

    assign w_accept_unmapped = io.in_hreadyin & w_unmapped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds_state <= DS_IDLE;
        end else begin
            r_ds_state <= w_ds_state_next;
        end
    end

    always_comb begin
        w_ds_state_next = r_ds_state;
        w_def_hreadyout = 1'b1;
        w_def_hresp     = 1'b0;
        case (r_ds_state)
            DS_IDLE: begin
                if (w_accept_unmapped) w_ds_state_next = DS_ERR1;
            end
            DS_ERR1: begin
                w_def_hreadyout = 1'b0;
                w_def_hresp     = 1'b1;
                w_ds_state_next = DS_ERR2;
            end
            DS_ERR2: begin
                w_def_hresp     = 1'b1;
                w_ds_state_next = w_accept_unmapped ? DS_ERR1 : DS_IDLE;
            end
            default: w_ds_state_next = DS_IDLE;
        endcase
    end
`else
    // Without the error slave, unmapped transfers complete OKAY with no wait.
    assign w_def_hreadyout = 1'b1;
    assign w_def_hresp     = 1'b0;
`endif

    always_comb begin
        w_hrdata    = 32'h0000_0000;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (r_dsel[i]) begin
                w_hrdata    = io.outs_hrdata[32*i +: 32];
                w_hreadyout = io.outs_hreadyout[i];
                w_hresp     = io.outs_hresp[i];
            end
        end
        if (r_dsel[3]) begin
            w_hreadyout = w_def_hreadyout;
            w_hresp     = w_def_hresp;
        end
    end

    assign io.in_hrdata    = w_hrdata;
    assign io.in_hreadyout = w_hreadyout;
    assign io.in_hresp     = w_hresp;
endmodule

// File: tb/tb_hasti_slave_demux.sv
// Directed bench for hasti_slave_demux; honours HASTI_DEMUX_ERRSLV_EN if defined.
module tb_hasti_slave_demux;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        resp;
        logic        is_write;
    } rsp_t;

    rsp_t sb[$];

    hasti_slave_demux_if bus();

    hasti_slave_demux dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    assign bus.in_hreadyin = bus.in_hreadyout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HASTI_DEMUX_ERRSLV_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input string tag, input logic [31:0] d, input logic r, input logic w);
        rsp_t e;
        e.tag = tag; e.data = d; e.resp = r; e.is_write = w;
        sb.push_back(e);
    endtask

    task automatic pop_rsp();
        rsp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_data"}, e.is_write ? bus.outs_hwdata : bus.in_hrdata, e.data);
            chk({e.tag, "_resp"}, {31'd0, bus.in_hresp}, {31'd0, e.resp});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w, input logic s);
        bus.in_haddr  = a;
        bus.in_htrans = t;
        bus.in_hwrite = w;
        bus.in_hsel   = s;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.in_haddr = 32'h0; bus.in_hwrite = 1'b0; bus.in_hsize = 3'd2;
        bus.in_hburst = 3'd0; bus.in_hprot = 4'h3; bus.in_htrans = 2'b00;
        bus.in_hmastlock = 1'b0; bus.in_hwdata = 32'h0; bus.in_hsel = 1'b0;
        bus.outs_hrdata = 96'h0; bus.outs_hreadyout = 3'b111; bus.outs_hresp = 3'b000;

        // Reset state
        @(negedge clk);
        chk("rst_hreadyout", {31'd0, bus.in_hreadyout}, 32'd1);
        chk("rst_hresp", {31'd0, bus.in_hresp}, 32'd0);
        chk("rst_hrdata", bus.in_hrdata, 32'h0);
        reset = 1'b0;
        next_cycle();

        // Read slave 0 with one wait state
        addr_phase(32'h0000_0010, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        chk("rd0_hsel", {29'd0, bus.outs_hsel}, 32'b001);
        chk("rd0_haddr_bcast", bus.outs_haddr, 32'h0000_0010);
        chk("rd0_addr_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        push_rsp("rd0", 32'hDEAD_BEEF, 1'b0, 1'b0);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        bus.outs_hreadyout = 3'b110;
        @(negedge clk);
        chk("rd0_wait_ready", {31'd0, bus.in_hreadyout}, 32'd0);
        next_cycle();
        bus.outs_hreadyout = 3'b111;
        bus.outs_hrdata[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd0_done_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        next_cycle();
        @(negedge clk);
        chk("rd0_idle_hrdata", bus.in_hrdata, 32'h0);

        // Back-to-back writes to slave 1 then slave 2
        next_cycle();
        bus.outs_hrdata = {32'h2222_2222, 32'h1111_1111, 32'h0};
        addr_phase(32'h0001_0004, 2'b10, 1'b1, 1'b1);
        @(negedge clk);
        chk("wr1_hsel", {29'd0, bus.outs_hsel}, 32'b010);
        push_rsp("wr1", 32'hA5A5_0001, 1'b0, 1'b1);
        next_cycle();
        addr_phase(32'h1000_0000, 2'b10, 1'b1, 1'b1);
        bus.in_hwdata = 32'hA5A5_0001;
        bus.outs_hresp = 3'b100;
        @(negedge clk);
        chk("wr2_hsel", {29'd0, bus.outs_hsel}, 32'b100);
        chk("wr1_owner_hrdata", bus.in_hrdata, 32'h1111_1111);
        chk("wr1_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        push_rsp("wr2", 32'hA5A5_0002, 1'b0, 1'b1);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        bus.in_hwdata = 32'hA5A5_0002;
        bus.outs_hresp = 3'b000;
        @(negedge clk);
        chk("wr2_owner_hrdata", bus.in_hrdata, 32'h2222_2222);
        pop_rsp();
        next_cycle();

        // Unmapped read
        bus.outs_hrdata = {3{32'h5A5A_5A5A}};
        addr_phase(32'h2000_0000, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        chk("um1_hsel", {29'd0, bus.outs_hsel}, 32'd0);
        chk("um1_addr_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        push_rsp("um1", 32'h0, ERR_EN, 1'b0);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
`ifdef HASTI_DEMUX_ERRSLV_EN
        chk("um1_err1_ready", {31'd0, bus.in_hreadyout}, 32'd0);
        chk("um1_err1_resp", {31'd0, bus.in_hresp}, 32'd1);
        chk("um1_err1_hrdata", bus.in_hrdata, 32'h0);
        next_cycle();
        addr_phase(32'h3000_0000, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        chk("um1_err2_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        push_rsp("um2", 32'h0, 1'b1, 1'b0);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("um2_err1_ready", {31'd0, bus.in_hreadyout}, 32'd0);
        chk("um2_err1_resp", {31'd0, bus.in_hresp}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("um2_err2_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        next_cycle();
`else
        chk("um1_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        next_cycle();
`endif
        @(negedge clk);
        chk("um_after_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        chk("um_after_resp", {31'd0, bus.in_hresp}, 32'd0);
        next_cycle();

        // IDLE to unmapped, then hsel=0 to mapped: no data phase either way
        addr_phase(32'h2000_0000, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        chk("idle_um_hsel", {29'd0, bus.outs_hsel}, 32'd0);
        next_cycle();
        addr_phase(32'h0000_0010, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_um_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        chk("idle_um_resp", {31'd0, bus.in_hresp}, 32'd0);
        chk("nosel_hsel", {29'd0, bus.outs_hsel}, 32'd0);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        bus.outs_hreadyout = 3'b110;
        @(negedge clk);
        chk("nosel_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        next_cycle();
        bus.outs_hreadyout = 3'b111;

        // Reset during a slave 2 wait state
        addr_phase(32'h1000_0004, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        chk("rs_hsel", {29'd0, bus.outs_hsel}, 32'b100);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        bus.outs_hreadyout = 3'b011;
        bus.outs_hresp = 3'b100;
        @(negedge clk);
        chk("rs_wait_ready", {31'd0, bus.in_hreadyout}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("rs_async_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        chk("rs_async_resp", {31'd0, bus.in_hresp}, 32'd0);
        next_cycle();
        @(negedge clk);
        reset = 1'b0;
        bus.outs_hreadyout = 3'b111;
        bus.outs_hresp = 3'b000;
        next_cycle();
        bus.outs_hrdata[63:32] = 32'hCAFE_F00D;
        addr_phase(32'h0001_0000, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rs_hsel", {29'd0, bus.outs_hsel}, 32'b010);
        push_rsp("post_rs_rd1", 32'hCAFE_F00D, 1'b0, 1'b0);
        next_cycle();
        addr_phase(32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rs_ready", {31'd0, bus.in_hreadyout}, 32'd1);
        pop_rsp();
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
